// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup, registered install/invalidate.
// Optional same-cycle write-to-lookup forwarding is enabled by defining BTB_WRITE_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module btb_assoc #(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2,
    parameter int TAG_BITS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [`XLEN-1:0]  query_pc,
    output logic              hit,
    output logic [`XLEN-1:0]  target_pc,
    input  logic              write_enable,
    input  logic [`XLEN-1:0]  write_source_pc,
    input  logic [`XLEN-1:0]  write_dest_pc,
    input  logic              inval_enable,
    input  logic [`XLEN-1:0]  inval_pc
);

    localparam int XLEN     = `XLEN;
    localparam int IDX_BITS = $clog2(NUM_SETS);
    // A single-way build still carries a 1-bit pointer; it is held at 0.
    localparam int PTR_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [TAG_BITS-1:0] tag_q    [NUM_SETS][NUM_WAYS];
    logic [XLEN-1:0]     target_q [NUM_SETS][NUM_WAYS];
    logic [PTR_BITS-1:0] rr_q     [NUM_SETS];

    function automatic logic [IDX_BITS-1:0] idx_of(input logic [XLEN-1:0] pc);
        return pc[IDX_BITS+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    endfunction

    logic [IDX_BITS-1:0] q_idx, w_idx, i_idx;
    logic [TAG_BITS-1:0] q_tag, w_tag, i_tag;

    assign q_idx = idx_of(query_pc);
    assign q_tag = tag_of(query_pc);
    assign w_idx = idx_of(write_source_pc);
    assign w_tag = tag_of(write_source_pc);
    assign i_idx = idx_of(inval_pc);
    assign i_tag = tag_of(inval_pc);

    // PC offset bits and bits above the tag never take part in indexing or matching.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{query_pc, write_source_pc, inval_pc};

    logic            arr_hit;
    logic [XLEN-1:0] arr_target;

    always_comb begin
        arr_hit    = 1'b0;
        arr_target = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[q_idx][w] && (tag_q[q_idx][w] == q_tag)) begin
                arr_hit    = 1'b1;
                arr_target = target_q[q_idx][w];
            end
        end
    end

`ifdef BTB_WRITE_BYPASS_EN
    logic bypass;
    assign bypass = write_enable && (w_idx == q_idx) && (w_tag == q_tag);

    always_comb begin
        hit       = arr_hit;
        target_pc = arr_target;
        if (bypass) begin
            hit       = 1'b1;
            target_pc = write_dest_pc;
        end
    end
`else
    always_comb begin
        hit       = arr_hit;
        target_pc = arr_target;
    end
`endif

    // Way selection for an install: existing match, else lowest free way, else round-robin victim.
    logic                w_match, w_free, w_evict;
    logic [PTR_BITS-1:0] w_match_way, w_free_way, w_way;

    always_comb begin
        w_match     = 1'b0;
        w_match_way = '0;
        w_free      = 1'b0;
        w_free_way  = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag)) begin
                w_match     = 1'b1;
                w_match_way = PTR_BITS'(w);
            end
            if (!valid_q[w_idx][w]) begin
                w_free     = 1'b1;
                w_free_way = PTR_BITS'(w);
            end
        end
        w_evict = !w_match && !w_free;
        if (w_match) begin
            w_way = w_match_way;
        end else if (w_free) begin
            w_way = w_free_way;
        end else begin
            w_way = rr_q[w_idx];
        end
    end

    logic [NUM_WAYS-1:0] i_mask;

    always_comb begin
        i_mask = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            i_mask[w] = valid_q[i_idx][w] && (tag_q[i_idx][w] == i_tag);
        end
    end

    // Invalidate is applied first so a same-entry install in the same cycle wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (inval_enable) begin
                valid_q[i_idx] <= valid_q[i_idx] & ~i_mask;
            end
            if (write_enable) begin
                valid_q[w_idx][w_way]  <= 1'b1;
                tag_q[w_idx][w_way]    <= w_tag;
                target_q[w_idx][w_way] <= write_dest_pc;
                if (w_evict && (NUM_WAYS > 1)) begin
                    rr_q[w_idx] <= rr_q[w_idx] + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer for the fetch stage.
- Lookup: combinational, same-cycle predicted target for the fetch PC.
- Updates: from the execute/retire path (resolved taken branch).
- Invalidation: for stale entries.
- Each entry holds a partial tag, so aliasing is bounded. Per-set round-robin replacement when a set is full.

Parameters:
NUM_SETS, 8, number of sets; power of two, >=2; IDX_BITS = $clog2(NUM_SETS)
NUM_WAYS, 2, ways per set; power of two, >=1
TAG_BITS, 8, stored tag width; IDX_BITS+TAG_BITS+2 <= `XLEN

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high; clears all valid bits and replacement pointers
query_pc  input  `XLEN  fetch PC to look up
hit  output  1  valid entry with matching tag found for query_pc
target_pc  output  `XLEN  stored target on hit; 0 on miss
write_enable  input  1  install/update an entry this cycle
write_source_pc  input  `XLEN  branch PC being installed
write_dest_pc  input  `XLEN  resolved target of that branch
inval_enable  input  1  invalidate the entry matching inval_pc
inval_pc  input  `XLEN  PC whose entry is cleared

Behaviour:
- Address split, any PC: index = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. pc[1:0] ignored.
- Storage per entry: valid, tag[TAG_BITS], target[`XLEN]. Per set: rr_ptr of $clog2(NUM_WAYS) bits (0 width when NUM_WAYS=1; victim is way 0).
- Lookup (combinational):
  - hit = OR over ways of (valid && tag == query tag) in set[query index].
  - target_pc = target of the lowest-numbered matching way; 0 when hit=0.
  - Reflects state registered at the last clock edge.
- Write (registered, effective next cycle):
  - Tag match in set: overwrite target of the lowest matching way; valid stays 1; rr_ptr unchanged.
  - Else, an invalid way exists: fill the lowest-numbered invalid way; rr_ptr unchanged.
  - Else: replace way rr_ptr; rr_ptr <= rr_ptr+1, wrapping modulo NUM_WAYS.
- Invalidate (registered): clear valid of every way in set[inval index] whose tag matches. No match -> no effect. rr_ptr unchanged.
- Simultaneous write and invalidate:
  - Same set and tag: write wins; the entry ends valid with the new target.
  - Different set or tag: both take effect.
- Duplicate prevention: at most one valid way per (set, tag) is ever created.
- Reset:
  - All valid=0, all rr_ptr=0, so hit=0 and target_pc=0 from the cycle after reset is sampled high.
  - Tag and target arrays need not be cleared.
  - reset dominates write_enable/inval_enable in the same cycle.
- Latency:
  - Lookup: 0 cycles.
  - Write/invalidate: visible to queries the cycle after the edge on which they are sampled.
- No handshake: write/inval are single-cycle pulses, always accepted.

Optional Feature:
BTB_WRITE_BYPASS_EN
- Defined: if write_enable is high and write_source_pc matches query_pc in index and tag, then hit=1 and target_pc=write_dest_pc in that same cycle. This overrides array contents and any same-cycle invalidate of that PC.
- Not defined: same-cycle query returns pre-write array contents (miss or old target).
- Storage updates are identical in both cases.

Test Plan:
1. Reset, then query 0x0000_0010 -> hit=0, target_pc=0.
2. Write src=0x0000_0010 dst=0x0000_0100; next cycle query 0x0000_0010 -> hit=1, target=0x0000_0100. Query 0x0000_0030 (same set 4, tag 1) -> hit=0.
3. Defaults, set 4: write 0x10->0x100, 0x30->0x300, then 0x50->0x500 (third tag, set full). Then:
   - query 0x10 -> miss (way 0 evicted, rr_ptr=1);
   - 0x30 -> 0x300;
   - 0x50 -> 0x500.
   Next write 0x70->0x700 evicts 0x30.
4. Write 0x10->0x100, then write 0x10->0x200 -> query 0x10 returns 0x200; only one way valid in set 4 (0x30 installed next lands in a free way without eviction).
5. Install 0x10; assert inval_pc=0x10 together with write 0x30->0x300 -> next cycle 0x10 misses, 0x30 hits 0x300. Then inval 0x30 and write 0x30->0x330 in the same cycle -> 0x30 hits 0x330.
6. Aliasing: install 0x0000_0010->0x100; query 0x0000_2010 (bit 13 outside the tag) -> hit=1, target 0x100. With BTB_WRITE_BYPASS_EN, write 0x90->0x900 while querying 0x90 -> hit=1, target 0x900 in that same cycle; without the macro -> hit=0.
